data_memory_sized: RTL



---
 rtl/data_memory_sized.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/data_memory_sized.sv
// Byte-addressed RV64 data memory: sized/signed loads, byte-lane stores, fault reporting, clear on reset.
// Completes LATENCY cycles after accept; ready is low while busy and requests seen then are dropped.
module data_memory_sized #(
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  memRead,
  input  logic                  memWrite,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [63:0]           writeData,
  output logic                  ready,
  output logic                  done,
  output logic                  fault,
  output logic [63:0]           readData
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int XW = ADDR_WIDTH - 3;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] CNT_LOAD  = CW'(LATENCY - 1);
  localparam logic [XW:0]   DEPTH_LIM = (XW + 1)'(DEPTH);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    rd_q, rd_d;
  logic                    wr_q, wr_d;
  logic [2:0]              f3_q, f3_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [63:0]             wdata_q, wdata_d;
  logic                    ready_q, ready_d;
  logic                    done_q, done_d;
  logic                    fault_q, fault_d;
  logic [63:0]             rdata_q, rdata_d;
  logic [63:0]             mem_q [DEPTH];

  logic [XW-1:0]           word_idx;
  logic [IW-1:0]           mem_idx;
  logic [5:0]              lane_sh;
  logic [63:0]             rd_word;
  logic [63:0]             shifted;
  logic [63:0]             size_mask;
  logic [63:0]             store_mask;
  logic [63:0]             store_word;
  logic [63:0]             load_val;
  logic                    misalign;
  logic                    bad;
  logic                    mem_we;

  // Datapath decode works only on the latched request, so inputs may change freely while busy.
  always_comb begin
    word_idx = addr_q[ADDR_WIDTH-1:3];
    mem_idx  = word_idx[IW-1:0];
    lane_sh  = {addr_q[2:0], 3'b000};
    rd_word  = mem_q[mem_idx];
    shifted  = rd_word >> lane_sh;
    case (f3_q[1:0])
      2'b00: begin
        size_mask = 64'h0000_0000_0000_00ff;
        misalign  = 1'b0;
        load_val  = f3_q[2] ? {56'd0, shifted[7:0]} : {{56{shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        size_mask = 64'h0000_0000_0000_ffff;
        misalign  = addr_q[0];
        load_val  = f3_q[2] ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      end
      2'b10: begin
        size_mask = 64'h0000_0000_ffff_ffff;
        misalign  = |addr_q[1:0];
        load_val  = f3_q[2] ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      end
      default: begin
        size_mask = '1;
        misalign  = |addr_q[2:0];
        load_val  = shifted;
      end
    endcase
    store_mask = size_mask << lane_sh;
    store_word = (rd_word & ~store_mask) | ((wdata_q << lane_sh) & store_mask);
    bad = (rd_q & wr_q) | (f3_q == 3'b111) | (wr_q & f3_q[2]) | misalign |
          ({1'b0, word_idx} >= DEPTH_LIM);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    fault_d = 1'b0;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (memRead | memWrite) begin
          rd_d    = memRead;
          wr_d    = memWrite;
          f3_d    = funct3;
          addr_d  = address;
          wdata_d = writeData;
          cnt_d   = CNT_LOAD;
          ready_d = 1'b0;
          state_d = BUSY;
        end
      end
      default: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          ready_d = 1'b1;
          done_d  = 1'b1;
          fault_d = bad;
          if (!bad) begin
            if (wr_q) mem_we = 1'b1;
            else      rdata_d = load_val;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      rdata_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      fault_q <= fault_d;
      rdata_q <= rdata_d;
      if (mem_we) mem_q[mem_idx] <= store_word;
    end
  end

  assign ready    = ready_q;
  assign done     = done_q;
  assign fault    = fault_q;
  assign readData = rdata_q;

endmodule
